// File: rtl/ika87ad_opfetch_pkg.sv
// Shared constants, state encoding and prefix decoding for the IKA87AD opcode fetch stage.
package IKA87AD_pkg;

    localparam logic [2:0] PAGE_NONE = 3'd0;
    localparam logic [2:0] PAGE_48   = 3'd1;
    localparam logic [2:0] PAGE_60   = 3'd2;
    localparam logic [2:0] PAGE_64   = 3'd3;
    localparam logic [2:0] PAGE_70   = 3'd4;
    localparam logic [2:0] PAGE_74   = 3'd5;

    localparam logic [7:0] PFX_48 = 8'h48;
    localparam logic [7:0] PFX_60 = 8'h60;
    localparam logic [7:0] PFX_64 = 8'h64;
    localparam logic [7:0] PFX_70 = 8'h70;
    localparam logic [7:0] PFX_74 = 8'h74;

    localparam logic [7:0] HARDI_OPCODE = 8'h73;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_HOLD   = 2'd2
    } opfetch_state_e;

    // Returns {is_prefix, page}; page is PAGE_NONE for ordinary opcodes.
    function automatic logic [3:0] prefix_to_page(input logic [7:0] b);
        case (b)
            PFX_48:  prefix_to_page = {1'b1, PAGE_48};
            PFX_60:  prefix_to_page = {1'b1, PAGE_60};
            PFX_64:  prefix_to_page = {1'b1, PAGE_64};
            PFX_70:  prefix_to_page = {1'b1, PAGE_70};
            PFX_74:  prefix_to_page = {1'b1, PAGE_74};
            default: prefix_to_page = {1'b0, PAGE_NONE};
        endcase
    endfunction

endpackage

// File: rtl/ika87ad_opfetch_prefetch_buf.sv
// One-entry byte buffer with full flag, used to overlap fetch with opcode hold.
module ika87ad_prefetch_buf (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       wr_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_i,
    output logic       full_o,
    output logic [7:0] data_o
);

    logic       full_q;
    logic [7:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end else if (wr_i) begin
            full_q <= 1'b1;
            data_q <= wr_data_i;
        end else if (rd_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/ika87ad_opfetch.sv
// Instruction register / prefix folding stage ahead of the opcode decoder.
// Define IKA87AD_OPFETCH_PREFETCH_EN to add a one-byte prefetch buffer for bubble-free issue.
module ika87ad_opfetch
    import IKA87AD_pkg::*;
#(
    parameter logic [7:0] HARDI_OP = HARDI_OPCODE,
    parameter logic [7:0] RESET_OP = 8'h00
) (
    input  logic       i_EMUCLK,
    input  logic       i_RESET_n,
    input  logic [7:0] i_FETCH_BYTE,
    input  logic       i_FETCH_VALID,
    output logic       o_FETCH_READY,
    input  logic       i_FLUSH,
    input  logic       i_HARDI_REQ,
    output logic       o_HARDI_ACK,
    output logic [7:0] o_OPCODE,
    output logic [2:0] o_OPCODE_PAGE,
    output logic       o_OP_VALID,
    input  logic       i_OP_ACCEPT,
    output logic       o_INJECTED,
    output logic       o_PREFIX_BUSY
);

    opfetch_state_e state_q, state_d;
    logic [7:0]     opcode_q, opcode_d;
    logic [2:0]     page_q, page_d;
    logic           inj_q, inj_d;
    logic           ack_q, ack_d;

    logic       fetch_ready;
    logic       fetch_take;
    logic       buf_full;
    logic [7:0] buf_data;
    logic       buf_wr, buf_pop, buf_clr;
    logic       src_valid;
    logic [7:0] src_byte;
    logic [3:0] src_pfx;
    logic       load_src;

`ifdef IKA87AD_OPFETCH_PREFETCH_EN
    ika87ad_prefetch_buf u_buf (
        .clk_i     (i_EMUCLK),
        .rst_ni    (i_RESET_n),
        .clr_i     (buf_clr),
        .wr_i      (buf_wr),
        .wr_data_i (i_FETCH_BYTE),
        .rd_i      (buf_pop),
        .full_o    (buf_full),
        .data_o    (buf_data)
    );
`else
    assign buf_full = 1'b0;
    assign buf_data = 8'h00;
    logic unused_buf_ctl;
    assign unused_buf_ctl = &{1'b0, buf_wr, buf_pop, buf_clr};
`endif

    always_comb begin
        fetch_ready = 1'b0;
        case (state_q)
            ST_IDLE:   fetch_ready = ~i_HARDI_REQ & ~i_FLUSH & ~buf_full;
            ST_PREFIX: fetch_ready = ~i_FLUSH;
`ifdef IKA87AD_OPFETCH_PREFETCH_EN
            ST_HOLD:   fetch_ready = ~buf_full & ~i_FLUSH;
`else
            ST_HOLD:   fetch_ready = 1'b0;
`endif
            default:   fetch_ready = 1'b0;
        endcase
    end

    // A buffered byte is always older than the bus byte, and ready is low while it is held.
    assign fetch_take = i_FETCH_VALID & fetch_ready;
    assign src_valid  = buf_full | fetch_take;
    assign src_byte   = buf_full ? buf_data : i_FETCH_BYTE;
    assign src_pfx    = prefix_to_page(src_byte);

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        page_d   = page_q;
        inj_d    = inj_q;
        ack_d    = 1'b0;
        buf_wr   = 1'b0;
        buf_clr  = 1'b0;
        load_src = 1'b0;
        if (i_FLUSH) begin
            state_d  = ST_IDLE;
            opcode_d = RESET_OP;
            page_d   = PAGE_NONE;
            inj_d    = 1'b0;
            buf_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_HARDI_REQ) begin
                        state_d  = ST_HOLD;
                        opcode_d = HARDI_OP;
                        page_d   = PAGE_NONE;
                        inj_d    = 1'b1;
                        ack_d    = 1'b1;
                    end else begin
                        load_src = src_valid;
                    end
                end
                ST_PREFIX: begin
                    if (fetch_take) begin
                        state_d  = ST_HOLD;
                        opcode_d = i_FETCH_BYTE;
                        inj_d    = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (i_OP_ACCEPT) begin
                        state_d  = ST_IDLE;
                        opcode_d = RESET_OP;
                        page_d   = PAGE_NONE;
                        inj_d    = 1'b0;
                        load_src = src_valid & ~i_HARDI_REQ;
                    end
                    buf_wr = fetch_take & ~load_src;
                end
                default: state_d = ST_IDLE;
            endcase
            // Shared by IDLE issue and the back-to-back path out of HOLD.
            if (load_src) begin
                if (src_pfx[3]) begin
                    state_d  = ST_PREFIX;
                    opcode_d = RESET_OP;
                    page_d   = src_pfx[2:0];
                end else begin
                    state_d  = ST_HOLD;
                    opcode_d = src_byte;
                    page_d   = PAGE_NONE;
                end
                inj_d = 1'b0;
            end
        end
    end

    assign buf_pop = load_src & buf_full;

    always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= RESET_OP;
            page_q   <= PAGE_NONE;
            inj_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            page_q   <= page_d;
            inj_q    <= inj_d;
            ack_q    <= ack_d;
        end
    end

    assign o_FETCH_READY = fetch_ready;
    assign o_HARDI_ACK   = ack_q;
    assign o_OPCODE      = opcode_q;
    assign o_OPCODE_PAGE = page_q;
    assign o_OP_VALID    = (state_q == ST_HOLD);
    assign o_INJECTED    = inj_q;
    assign o_PREFIX_BUSY = (state_q == ST_PREFIX);

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Randomised and directed check of ika87ad_opfetch against a transaction-level reference model.
module tb_ika87ad_opfetch;

`ifdef IKA87AD_OPFETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fbyte = 8'h00;
    logic       fvalid = 1'b0;
    logic       flush = 1'b0;
    logic       hardi = 1'b0;
    logic       accept = 1'b0;
    logic       fready, ack, op_valid, injected, busy;
    logic [7:0] opcode;
    logic [2:0] page;

    int n_checks = 0;
    int n_errors = 0;

    ika87ad_opfetch dut (
        .i_EMUCLK      (clk),
        .i_RESET_n     (rst_n),
        .i_FETCH_BYTE  (fbyte),
        .i_FETCH_VALID (fvalid),
        .o_FETCH_READY (fready),
        .i_FLUSH       (flush),
        .i_HARDI_REQ   (hardi),
        .o_HARDI_ACK   (ack),
        .o_OPCODE      (opcode),
        .o_OPCODE_PAGE (page),
        .o_OP_VALID    (op_valid),
        .i_OP_ACCEPT   (accept),
        .o_INJECTED    (injected),
        .o_PREFIX_BUSY (busy)
    );

    always #5 clk = ~clk;

    // Reference model: an instruction is either being assembled (pending prefix) or held.
    bit         m_held, m_pfx, m_inj, m_ack;
    logic [7:0] m_op;
    int         m_pg, m_pfx_pg;
    logic [7:0] m_buf[$];
    logic [7:0] pfx_list[5] = '{8'h48, 8'h60, 8'h64, 8'h70, 8'h74};

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int page_of(input logic [7:0] b);
        for (int i = 0; i < 5; i++) if (pfx_list[i] == b) return i + 1;
        return 0;
    endfunction

    function automatic bit exp_ready();
        if (m_held)     return PF && m_buf.size() == 0 && !flush;
        else if (m_pfx) return !flush;
        else            return !hardi && !flush && m_buf.size() == 0;
    endfunction

    task automatic model_reset();
        m_held = 0; m_pfx = 0; m_inj = 0; m_ack = 0; m_op = 8'h00; m_pg = 0; m_pfx_pg = 0;
        m_buf.delete();
    endtask

    task automatic feed(input logic [7:0] b);
        int p;
        p = page_of(b);
        if (p != 0) begin
            m_pfx = 1; m_pfx_pg = p;
        end else begin
            m_held = 1; m_op = b; m_pg = 0; m_inj = 0;
        end
    endtask

    task automatic model_step();
        bit take;
        take  = fvalid && exp_ready();
        m_ack = 0;
        if (flush) begin
            m_held = 0; m_pfx = 0; m_inj = 0; m_buf.delete();
        end else if (m_held) begin
            if (accept) begin
                m_held = 0; m_inj = 0;
                if (m_buf.size() > 0 && !hardi) feed(m_buf.pop_front());
                else if (take && !hardi)        feed(fbyte);
                else if (take)                  m_buf.push_back(fbyte);
            end else if (take) begin
                m_buf.push_back(fbyte);
            end
        end else if (m_pfx) begin
            if (take) begin
                m_pfx = 0; m_held = 1; m_op = fbyte; m_pg = m_pfx_pg; m_inj = 0;
            end
        end else begin
            if (hardi) begin
                m_held = 1; m_op = 8'h73; m_pg = 0; m_inj = 1; m_ack = 1;
            end else if (m_buf.size() > 0) begin
                feed(m_buf.pop_front());
            end else if (take) begin
                feed(fbyte);
            end
        end
    endtask

    task automatic check_outputs();
        chk("ready",  fready,   exp_ready());
        chk("valid",  op_valid, m_held);
        chk("opcode", opcode,   m_held ? m_op : 8'h00);
        chk("page",   page,     m_held ? m_pg : (m_pfx ? m_pfx_pg : 0));
        chk("inj",    injected, m_held && m_inj);
        chk("busy",   busy,     m_pfx);
        chk("ack",    ack,      m_ack);
    endtask

    // One bus cycle: drive after the falling edge, check, then advance the model for the next rise.
    task automatic cyc(input bit v, input logic [7:0] b, input bit h, input bit f, input bit a);
        @(negedge clk);
        fvalid = v; fbyte = b; hardi = h; flush = f; accept = a;
        #1;
        check_outputs();
        $display("t=%0t v=%0b b=%02h h=%0b f=%0b a=%0b -> rdy=%0b val=%0b op=%02h pg=%0d inj=%0b busy=%0b ack=%0b",
                 $time, v, b, h, f, a, fready, op_valid, opcode, page, injected, busy, ack);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; fvalid = 0; hardi = 0; flush = 0; accept = 0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        do_reset();

        cyc(1, 8'h54, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(1, 8'h11, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);

        cyc(1, 8'h70, 0, 0, 0);
        cyc(1, 8'h6A, 1, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);

        cyc(1, 8'h48, 0, 0, 0);
        cyc(1, 8'h48, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);

        cyc(1, 8'h00, 1, 0, 0);
        cyc(1, 8'h00, 0, 0, 0);
        cyc(1, 8'h00, 0, 0, 1);
        cyc(1, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);

        cyc(1, 8'h74, 0, 0, 0);
        cyc(1, 8'h12, 0, 1, 1);
        cyc(0, 8'h00, 0, 0, 0);

        if (PF) begin
            cyc(1, 8'h01, 0, 0, 1);
            cyc(1, 8'h60, 0, 0, 1);
            cyc(1, 8'h8A, 0, 0, 1);
            cyc(0, 8'h00, 0, 0, 1);
            cyc(0, 8'h00, 0, 0, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            if (i == 1500) do_reset();
            b = ($urandom_range(0, 2) == 0) ? pfx_list[$urandom_range(0, 4)] : 8'($urandom);
            cyc($urandom_range(0, 3) != 0, b, $urandom_range(0, 5) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
